// File: rtl/global_mem_master.sv
// rtl/global_mem_master.sv - burst initiator for the global SRAM word interface
//
// Turns one burst command (start address, length, direction) into back-to-back
// single-word accesses on the global_mem_* word interface. Write words come in
// on a valid/ready stream. Read words return through a small FIFO that applies
// backpressure to the issue logic.
//
// Optional feature: define GMEM_MASTER_TIMEOUT_EN to enable the read-return
// watchdog. When it is not defined, err is tied low and a lost return leaves
// the block in DRAIN until reset.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_vld/cmd_rdy       command handshake (cmd_rdy high only in IDLE)
//   cmd_wr/addr/len       burst direction, first word address, word count (0 = empty)
//   wr_data/vld/rdy       write data stream into the block
//   rd_data/vld/rdy       read data stream out of the block (FIFO head)
//   busy                  high whenever the FSM is not IDLE
//   done                  one-cycle pulse at burst completion
//   err                   sticky watchdog flag, cleared when the next command is accepted
//   global_mem_addr/wdata registered word address and write word to the SRAM wrapper
//   global_mem_wen/ren    registered write/read strobes, never high together
//   global_mem_rdata/rvld read return from the SRAM wrapper

`ifndef GLOBAL_MEM_ADDR_WIDTH
`define GLOBAL_MEM_ADDR_WIDTH 10
`endif
`ifndef GLOBAL_MEM_DATA_WIDTH
`define GLOBAL_MEM_DATA_WIDTH 16
`endif

module global_mem_master #(
  parameter int ADDR_W     = `GLOBAL_MEM_ADDR_WIDTH,
  parameter int DATA_W     = `GLOBAL_MEM_DATA_WIDTH,
  parameter int LEN_W      = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TO_CYC     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_vld,
  output logic              wr_rdy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] global_mem_addr,
  output logic [DATA_W-1:0] global_mem_wdata,
  output logic              global_mem_wen,
  output logic              global_mem_ren,
  input  logic [DATA_W-1:0] global_mem_rdata,
  input  logic              global_mem_rvld
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Full-rate reads need one FIFO slot per word in flight plus one.
  localparam bit PARAMS_OK = (FIFO_DEPTH >= RD_LAT + 1) && (TO_CYC > 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] cur;
  logic [LEN_W-1:0]  rem;
  logic [CNT_W-1:0]  outst;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic              accept;
  logic              wr_take;
  logic              issue;
  logic              ret_ok;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              to_hit;
  logic [CNT_W:0]    credit_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshakes and datapath qualifiers
  // ---------------------------------------------------------------------------
  assign cmd_rdy  = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign accept   = cmd_vld & cmd_rdy;

  assign wr_rdy   = (state == S_WRITE) && (rem != '0);
  assign wr_take  = wr_vld & wr_rdy;

  // Every issued read owns a FIFO slot until it is popped, so the FIFO can
  // never be pushed while full regardless of what rd_rdy does.
  assign credit_used = {1'b0, outst} + {1'b0, fifo_cnt};
  assign issue    = (state == S_READ) && (rem != '0) &&
                    (credit_used < (CNT_W + 1)'(FIFO_DEPTH)) && !to_hit;

  // Returns with nothing outstanding (e.g. left over from before a reset)
  // are dropped here rather than corrupting the FIFO or the credit count.
  assign ret_ok    = global_mem_rvld && (outst != '0);
  assign fifo_push = ret_ok;
  assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign rd_vld    = (fifo_cnt != '0);
  assign fifo_pop  = rd_vld & rd_rdy;
  assign rd_data   = fifo_mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Read-return watchdog
  // ---------------------------------------------------------------------------
`ifdef GMEM_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC);

  logic [TO_W-1:0] to_cnt;
  logic            to_run;
  logic            err_q;

  assign to_run = ((state == S_READ) || (state == S_DRAIN)) && (outst != '0);
  assign to_hit = to_run && !global_mem_rvld && (to_cnt == TO_W'(TO_CYC - 1));
  assign err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (!to_run || global_mem_rvld || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (to_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_len == '0) begin
            state_nx = S_DONE;
          end else if (cmd_wr) begin
            state_nx = S_WRITE;
          end else begin
            state_nx = S_READ;
          end
        end
      end
      // Leaving WRITE one cycle after the last word is taken lines done up
      // with the cycle after the final wen.
      S_WRITE: begin
        if (rem == '0) begin
          state_nx = S_DONE;
        end
      end
      S_READ: begin
        if (to_hit) begin
          state_nx = S_DONE;
        end else if (rem == '0) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (to_hit) begin
          state_nx = S_DONE;
        end else if ((outst == '0) && (fifo_cnt == '0)) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Burst counters and registered SRAM interface
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur              <= '0;
      rem              <= '0;
      global_mem_addr  <= '0;
      global_mem_wdata <= '0;
      global_mem_wen   <= 1'b0;
      global_mem_ren   <= 1'b0;
    end else begin
      global_mem_wen <= wr_take;
      global_mem_ren <= issue;

      if (accept) begin
        cur <= cmd_addr;
        rem <= cmd_len;
      end else if (wr_take || issue) begin
        // cur wraps modulo 2^ADDR_W by plain overflow.
        cur <= cur + 1'b1;
        rem <= rem - 1'b1;
      end else if (to_hit) begin
        rem <= '0;
      end

      if (wr_take) begin
        global_mem_addr  <= cur;
        global_mem_wdata <= wr_data;
      end else if (issue) begin
        global_mem_addr  <= cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else if (to_hit) begin
      outst <= '0;
    end else begin
      unique case ({issue, ret_ok})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read return FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (fifo_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= global_mem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Simulation checks
  // ---------------------------------------------------------------------------
  a_params_ok : assert property (@(posedge clk) disable iff (!rst_n) PARAMS_OK);
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
                                   !(fifo_push && fifo_full));
  a_strobe_excl : assert property (@(posedge clk) disable iff (!rst_n)
                                   !(global_mem_wen && global_mem_ren));

endmodule
